// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX->MEM pipeline register with 2-entry skid buffer
// ex_ready is registered so MEM backpressure never reaches EX combinationally.
module ex_mem_skid_reg #(
   parameter int DATA_W      = 32,
   parameter int RD_W        = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   ex_valid,
   output logic                   ex_ready,
   input  logic [DATA_W-1:0]      ex_alu_result,
   input  logic [DATA_W-1:0]      ex_store_data,
   input  logic [RD_W-1:0]        ex_rd,
   input  logic [3:0]             ex_ctrl,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic [DATA_W-1:0]      mem_alu_result,
   output logic [DATA_W-1:0]      mem_store_data,
   output logic [RD_W-1:0]        mem_rd,
   output logic                   mem_MemRead,
   output logic                   mem_MemWrite,
   output logic                   mem_RegWrite,
   output logic                   mem_MemtoReg,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int BEAT_W = 2 * DATA_W + RD_W + 4;

   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

   state_t                  state_q, state_d;
   logic                    ex_ready_q;
   logic [BEAT_W-1:0]       main_q, skid_q;
   logic [STALL_CNT_W-1:0]  stall_q;
   logic                    acc, dq;
   logic                    load_main_ex, load_main_skid, load_skid, clear_skid;
   logic [BEAT_W-1:0]       beat_in;

   assign beat_in   = {ex_alu_result, ex_store_data, ex_rd, ex_ctrl};
   assign mem_valid = (state_q != EMPTY);
   assign acc       = ex_valid & ex_ready_q;
   assign dq        = mem_valid & mem_ready;

   always_comb begin
      state_d        = state_q;
      load_main_ex   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_skid     = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d      = BUSY;
                  load_main_ex = 1'b1;
               end
            end
            BUSY: begin
               if (acc && !dq) begin
                  state_d   = FULL;
                  load_skid = 1'b1;
               end else if (acc && dq) begin
                  load_main_ex = 1'b1;
               end else if (dq) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (dq) begin
                  state_d        = BUSY;
                  load_main_skid = 1'b1;
                  clear_skid     = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         ex_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         ex_ready_q <= (state_d != FULL);
         if (load_main_ex) begin
            main_q <= beat_in;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= beat_in;
         end else if (clear_skid) begin
            skid_q <= '0;
         end
         // Counter keeps running through flush; it only saturates.
         if (mem_valid && !mem_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
         end
      end
   end

   assign ex_ready       = ex_ready_q;
   assign mem_alu_result = main_q[BEAT_W-1 -: DATA_W];
   assign mem_store_data = main_q[RD_W+4 +: DATA_W];
   assign mem_rd         = main_q[4 +: RD_W];
   // Memory/regfile side effects are masked on bubbles even if stale ctrl is held.
   assign mem_MemRead    = main_q[3] & mem_valid;
   assign mem_MemWrite   = main_q[2] & mem_valid;
   assign mem_RegWrite   = main_q[1] & mem_valid;
   assign mem_MemtoReg   = main_q[0];
   assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - self-checking bench for ex_mem_skid_reg
// Reference model: a FIFO queue of capacity two plus saturating stall counters.
module tb_ex_mem_skid_reg;

   logic        clk = 1'b0;
   logic        rst_n, flush, ex_valid, mem_ready;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_ctrl;

   logic        ex_ready, mem_valid, mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg;
   logic [31:0] mem_alu_result, mem_store_data;
   logic [4:0]  mem_rd;
   logic [15:0] stall_cycles;

   logic        s_ex_ready, s_mem_valid, s_rdm, s_wrm, s_rgw, s_m2r;
   logic [31:0] s_alu, s_store;
   logic [4:0]  s_rd;
   logic [3:0]  s_stall;

   int total = 0;
   int bad   = 0;

   logic [72:0] mq[$];
   logic [31:0] delivered[$];
   int unsigned stall_big, stall_small;

   always #5 clk = ~clk;

   ex_mem_skid_reg dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_alu_result(mem_alu_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_MemRead(mem_MemRead),
      .mem_MemWrite(mem_MemWrite), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
      .stall_cycles(stall_cycles)
   );

   ex_mem_skid_reg #(.STALL_CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(s_ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
      .mem_valid(s_mem_valid), .mem_ready(mem_ready), .mem_alu_result(s_alu),
      .mem_store_data(s_store), .mem_rd(s_rd), .mem_MemRead(s_rdm),
      .mem_MemWrite(s_wrm), .mem_RegWrite(s_rgw), .mem_MemtoReg(s_m2r),
      .stall_cycles(s_stall)
   );

   function automatic logic [74:0] model_vec();
      logic [72:0] f;
      if (mq.size() == 0) return {1'b1, 4'b0, 70'b0};
      f = mq[0];
      return {(mq.size() < 2), 1'b1, f[3], f[2], f[1], f[72:41], f[40:9], f[8:4], f[0]};
   endfunction

   function automatic logic [74:0] obs_vec();
      return {ex_ready, mem_valid, mem_MemRead, mem_MemWrite, mem_RegWrite,
              mem_valid ? {mem_alu_result, mem_store_data, mem_rd, mem_MemtoReg} : 70'b0};
   endfunction

   task automatic set_beat(input logic [31:0] alu, input logic [3:0] ctrl);
      ex_alu_result = alu;
      ex_store_data = $urandom;
      ex_rd         = 5'($urandom);
      ex_ctrl       = ctrl;
   endtask

   // Advances one clock and the reference model; returns whether EX's beat was taken.
   task automatic tick(output bit acc);
      bit          dq;
      logic [72:0] b;
      acc = ex_valid && (mq.size() < 2);
      dq  = (mq.size() > 0) && mem_ready;
      b   = {ex_alu_result, ex_store_data, ex_rd, ex_ctrl};
      if (mq.size() > 0 && !mem_ready) begin
         if (stall_big < 65535) stall_big++;
         if (stall_small < 15) stall_small++;
      end
      @(posedge clk);
      if (dq) begin
         delivered.push_back(mq[0][72:41]);
         void'(mq.pop_front());
      end
      if (flush) mq.delete();
      else if (acc) mq.push_back(b);
      acc = acc && !flush;
      @(negedge clk);
   endtask

   task automatic model_reset();
      mq.delete();
      stall_big   = 0;
      stall_small = 0;
   endtask

   task automatic test_reset();
      bit a;
      rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
      set_beat(32'h0, 4'h0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ex_valid = 1'b1; set_beat(32'h55, 4'hF); tick(a);
      set_beat(32'h66, 4'hF); tick(a);
      ex_valid = 1'b0; tick(a);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg} !== {1'b1, 1'b0, 73'b0}) begin
         bad++;
         $display("FAIL reset_outputs got ready=%b valid=%b alu=%h store=%h rd=%h ctrl=%b%b%b%b expected ready=1 valid=0 rest=0",
                  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
                  mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg);
      end
      total++;
      if (stall_cycles !== 16'd0 || s_stall !== 4'd0) begin
         bad++;
         $display("FAIL reset_stall got %0d/%0d expected 0/0", stall_cycles, s_stall);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_saturation();
      bit a;
      mem_ready = 1'b0; ex_valid = 1'b1; set_beat(32'h77, 4'h2);
      tick(a);
      ex_valid = 1'b0;
      repeat (20) tick(a);
      total++;
      if (s_stall !== 4'd15) begin
         bad++;
         $display("FAIL saturation_small got %0d expected 15", s_stall);
      end
      total++;
      if (stall_cycles !== 16'd20) begin
         bad++;
         $display("FAIL saturation_big got %0d expected 20", stall_cycles);
      end
      mem_ready = 1'b1;
      repeat (2) tick(a);
      total++;
      if (obs_vec() !== model_vec()) begin
         bad++;
         $display("FAIL saturation_drain got %h expected %h", obs_vec(), model_vec());
      end
   endtask

   task automatic test_streaming();
      bit a;
      logic [31:0] vals[3] = '{32'h10, 32'h14, 32'h18};
      delivered.delete();
      mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ex_valid = (i < 3);
         if (i < 3) set_beat(vals[i], 4'($urandom));
         tick(a);
         total++;
         if (obs_vec() !== model_vec() || ex_ready !== 1'b1) begin
            bad++;
            $display("FAIL streaming_cycle%0d got %h expected %h", i, obs_vec(), model_vec());
         end
      end
      total++;
      if (delivered.size() != 3 || delivered[0] !== 32'h10 || delivered[1] !== 32'h14 || delivered[2] !== 32'h18) begin
         bad++;
         $display("FAIL streaming_order got %p expected 10 14 18", delivered);
      end
   endtask

   task automatic test_skid();
      bit a;
      int idx = 0;
      int unsigned s0 = stall_big;
      logic [31:0] vals[3] = '{32'hA0, 32'hA4, 32'hA8};
      delivered.delete();
      for (int c = 0; c < 8; c++) begin
         mem_ready = (c >= 4);
         ex_valid  = (idx < 3);
         if (idx < 3) set_beat(vals[idx], 4'h2);
         tick(a);
         if (a) idx++;
         total++;
         if (obs_vec() !== model_vec()) begin
            bad++;
            $display("FAIL skid_cycle%0d got %h expected %h", c, obs_vec(), model_vec());
         end
         if (c == 1) begin
            total++;
            if (ex_ready !== 1'b0) begin
               bad++;
               $display("FAIL skid_full_ready got %b expected 0", ex_ready);
            end
         end
      end
      total++;
      if (delivered.size() != 3 || delivered[0] !== 32'hA0 || delivered[1] !== 32'hA4 || delivered[2] !== 32'hA8) begin
         bad++;
         $display("FAIL skid_order got %p expected a0 a4 a8", delivered);
      end
      total++;
      if (32'(stall_cycles) - s0 !== 32'd3) begin
         bad++;
         $display("FAIL skid_stall_count got %0d expected 3", 32'(stall_cycles) - s0);
      end
   endtask

   task automatic test_flush();
      bit a;
      int n;
      mem_ready = 1'b0; ex_valid = 1'b1;
      set_beat(32'hB0, 4'b0100); tick(a);
      set_beat(32'hB4, 4'b0100); tick(a);
      flush = 1'b1; set_beat(32'hB8, 4'b0100); tick(a);
      flush = 1'b0; ex_valid = 1'b0;
      total++;
      if (mem_valid !== 1'b0 || mem_MemWrite !== 1'b0 || ex_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_state got valid=%b wr=%b ready=%b expected 0 0 1", mem_valid, mem_MemWrite, ex_ready);
      end
      n = delivered.size();
      mem_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick(a);
         total++;
         if (mem_valid !== 1'b0 || mem_MemWrite !== 1'b0 || obs_vec() !== model_vec()) begin
            bad++;
            $display("FAIL flush_after%0d got valid=%b wr=%b expected 0 0", c, mem_valid, mem_MemWrite);
         end
      end
      total++;
      if (delivered.size() != n) begin
         bad++;
         $display("FAIL flush_no_beat got %0d beats expected %0d", delivered.size(), n);
      end
   endtask

   task automatic test_bubble();
      bit a;
      ex_valid = 1'b0;
      set_beat(32'hC0, 4'b0100);
      for (int c = 0; c < 8; c++) begin
         mem_ready = 1'($urandom);
         tick(a);
         total++;
         if (mem_MemWrite !== 1'b0 || s_wrm !== 1'b0) begin
            bad++;
            $display("FAIL bubble_gating%0d got %b/%b expected 0", c, mem_MemWrite, s_wrm);
         end
      end
   endtask

   task automatic test_random();
      bit a;
      for (int c = 0; c < 400; c++) begin
         ex_valid  = ($urandom_range(0, 9) < 7);
         mem_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         set_beat($urandom, 4'($urandom));
         tick(a);
         total++;
         if (obs_vec() !== model_vec()) begin
            bad++;
            $display("FAIL random_outputs%0d got %h expected %h", c, obs_vec(), model_vec());
         end
         total++;
         if (stall_cycles !== 16'(stall_big) || s_stall !== 4'(stall_small)) begin
            bad++;
            $display("FAIL random_stall%0d got %0d/%0d expected %0d/%0d", c, stall_cycles, s_stall, stall_big, stall_small);
         end
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_streaming();
      test_skid();
      test_flush();
      test_bubble();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
